// File: rtl/prefix_adder_pipe.sv
// Pipelined Sklansky prefix adder/subtractor with valid/ready handshake on both sides.
// Define PREFIX_ADDER_SAT_EN to clamp the result on signed overflow.
module prefix_adder_pipe #(
  parameter int WIDTH      = 16,
  parameter int PIPE_DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int LOG_W = $clog2(WIDTH);

  typedef struct packed {
    logic             valid;
    logic             c0;
    logic             aMsb;
    logic             bMsb;
    logic [WIDTH-1:0] pSum;
    logic [WIDTH-1:0] gv;
    logic [WIDTH-1:0] pv;
  } stage_t;

  // Prefix level after which internal rank k is registered.
  function automatic int rankLevel(input int k);
    return (k * LOG_W) / (PIPE_DEPTH + 1);
  endfunction

  // Applies Sklansky levels lo+1..hi to the (G,P) vectors of a stage bundle.
  function automatic stage_t prefixSpan(input stage_t x, input int lo, input int hi);
    stage_t           r;
    logic [WIDTH-1:0] gPrev;
    logic [WIDTH-1:0] pPrev;
    int               j;
    r = x;
    for (int l = lo + 1; l <= hi; l++) begin
      gPrev = r.gv;
      pPrev = r.pv;
      for (int i = 0; i < WIDTH; i++) begin
        if (((i >> (l - 1)) & 1) == 1) begin
          j       = ((i >> (l - 1)) << (l - 1)) - 1;
          r.gv[i] = gPrev[i] | (pPrev[i] & gPrev[j]);
          r.pv[i] = pPrev[i] & pPrev[j];
        end
      end
    end
    return r;
  endfunction

  logic             advance;
  logic             outValid_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;

  assign advance  = !outValid_q || out_ready;
  assign in_ready = advance;

  logic             valid0_q;
  logic [WIDTH-1:0] a0_q;
  logic [WIDTH-1:0] bEff0_q;
  logic             c00_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid0_q <= 1'b0;
      a0_q     <= '0;
      bEff0_q  <= '0;
      c00_q    <= 1'b0;
    end else if (advance) begin
      valid0_q <= in_valid;
      if (in_valid) begin
        a0_q    <= a;
        bEff0_q <= sub ? ~b : b;
        c00_q   <= sub | cin;
      end
    end
  end

  stage_t st [0:PIPE_DEPTH];

  assign st[0] = {valid0_q, c00_q, a0_q[WIDTH-1], bEff0_q[WIDTH-1],
                  a0_q ^ bEff0_q, a0_q & bEff0_q, a0_q ^ bEff0_q};

  for (genvar k = 1; k <= PIPE_DEPTH; k++) begin : gRank
    localparam int LO = rankLevel(k - 1);
    localparam int HI = rankLevel(k);
    stage_t rank_d;
    stage_t rank_q;

    assign rank_d = prefixSpan(st[k-1], LO, HI);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rank_q <= '0;
      end else if (advance) begin
        rank_q <= rank_d;
      end
    end

    assign st[k] = rank_q;
  end

  stage_t           fin;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sumRaw;
  logic [WIDTH-1:0] s_d;
  logic             cout_d;
  logic             ovf_d;

  // Finish the remaining prefix levels, then form carries, sum and flags.
  always_comb begin
    fin      = prefixSpan(st[PIPE_DEPTH], rankLevel(PIPE_DEPTH), LOG_W);
    carry    = '0;
    carry[0] = fin.c0;
    for (int i = 1; i < WIDTH; i++) begin
      carry[i] = fin.gv[i-1] | (fin.pv[i-1] & fin.c0);
    end
    sumRaw = fin.pSum ^ carry;
    cout_d = fin.gv[WIDTH-1] | (fin.pv[WIDTH-1] & fin.c0);
    ovf_d  = (fin.aMsb == fin.bMsb) && (sumRaw[WIDTH-1] != fin.aMsb);
    s_d    = sumRaw;
`ifdef PREFIX_ADDER_SAT_EN
    if (ovf_d) begin
      s_d = fin.aMsb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Result fields only update on valid beats so bubbles leave the last result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      s_q        <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (advance) begin
      outValid_q <= fin.valid;
      if (fin.valid) begin
        s_q    <= s_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid = outValid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
